// File: rtl/sdp_ram_pkg.sv
// sdp_ram_pkg: shared constants, helpers and state encoding for sdp_ram
package sdp_ram_pkg;
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;
    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction
    typedef enum logic {CLEAR, IDLE} ram_state_t;
endpackage

// File: rtl/sdp_ram_clr_fsm.sv
// sdp_ram_clr_fsm: sweeps zeros through the array after reset or on a clear request
module sdp_ram_clr_fsm
    import sdp_ram_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);
    ram_state_t        state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              busy_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                default: begin
                    if (clr) begin
                        state_q <= CLEAR;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
            endcase
        end
    end
    assign busy     = busy_q;
    assign clr_we   = state_q == CLEAR;
    assign clr_addr = ptr_q;
endmodule

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM with byte enables, selectable read latency,
// read-during-write mode and a hardware clear sweep
module sdp_ram
    import sdp_ram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int DEPTH    = 16,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = RDW_OLD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    output logic                busy,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                err
);
    localparam int              BE_W    = be_width(DATA_W);
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("sdp_ram: RD_LAT must be 1 or 2");
    end
    if (DATA_W % 8 != 0 || DEPTH < 1 || DEPTH > 2 ** ADDR_W) begin : g_bad_geom
        $error("sdp_ram: illegal DATA_W/DEPTH/ADDR_W combination");
    end
    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    sdp_ram_clr_fsm #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fsm (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy), .clr_we(clr_we), .clr_addr(clr_addr)
    );
    logic              wr_ok, wr_acc, rd_ok, rd_acc, hit;
    logic [DATA_W-1:0] old_w, merged, rd_d;
    assign wr_ok  = {1'b0, wr_addr} < DEPTH_V;
    assign rd_ok  = {1'b0, rd_addr} < DEPTH_V;
    assign wr_acc = !busy && wr_en && wr_ok;
    assign rd_acc = !busy && rd_en;
    assign old_w  = mem[wr_addr];
    for (genvar b = 0; b < BE_W; b++) begin : g_be
        assign merged[8*b +: 8] = wr_be[b] ? wr_data[8*b +: 8] : old_w[8*b +: 8];
    end
    // Bypass forwards the merged word so unselected bytes still show array contents
    assign hit  = RDW_MODE == RDW_NEW && wr_acc && wr_addr == rd_addr;
    assign rd_d = !rd_ok ? '0 : hit ? merged : mem[rd_addr];
    always_ff @(posedge clk) begin
        if (clr_we || wr_acc) mem[clr_we ? clr_addr : wr_addr] <= clr_we ? '0 : merged;
    end
    logic              v1_q, e1_q, v2_q, e2_q;
    logic [DATA_W-1:0] d1_q, d2_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            e1_q <= 1'b0;
            d1_q <= '0;
            v2_q <= 1'b0;
            e2_q <= 1'b0;
            d2_q <= '0;
        end else begin
            v1_q <= rd_acc;
            e1_q <= rd_acc && !rd_ok;
            if (rd_acc) d1_q <= rd_d;
            v2_q <= v1_q;
            e2_q <= e1_q;
            if (v1_q) d2_q <= d1_q;
        end
    end
    assign rd_data  = RD_LAT == 2 ? d2_q : d1_q;
    assign rd_valid = RD_LAT == 2 ? v2_q : v1_q;
    assign err      = RD_LAT == 2 ? e2_q : e1_q;
endmodule
